// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, defaults and helpers for the data-memory responder.
//   state_t          - responder FSM states (IDLE, WAIT)
//   DEFAULT_DEPTH    - default array depth in 32-bit words
//   DEFAULT_LATENCY  - default wait-state count per access
//   is_legal()       - access legality: index in range and not read+write at once
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_DEPTH   = 256;
    localparam int unsigned DEFAULT_LATENCY = 1;

    // Any address bit above the index field makes the access illegal; there is
    // no aliasing onto the array.
    function automatic logic is_legal(
        input logic [31:0] addr,
        input logic        rd,
        input logic        wr,
        input int unsigned idx_w
    );
        logic [31:0] upper;
        upper = addr >> idx_w;
        return (upper == '0) && !(rd && wr);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 storage, no reset.
//   clk   - write clock
//   we    - write enable, sampled on rising clk
//   waddr - write word index
//   wdata - write data
//   raddr - read word index (asynchronous read)
//   rdata - read data
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory responder for the execute stage.
// Each access takes LATENCY wait-state cycles (stall high) and then completes.
//   clk          - clock, all state changes on rising edge
//   rst_n        - asynchronous active-low reset
//   mem_read_en  - load request
//   mem_write_en - store request
//   mem_addr     - word address
//   mem_data_out - store data
//   mem_data_in  - load data, nonzero only in a read completion cycle
//   mem_stall    - high while execute must hold its request
//   mem_fault    - sticky illegal-access flag
//   fault_addr   - address of the first faulting access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH,
    parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_out,
    output logic [31:0] mem_data_in,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [31:0] fault_addr
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_t      state, state_d;
    logic [2:0]  cnt, cnt_d;
    logic [31:0] lat_addr, lat_data;
    logic        lat_rd, lat_wr;

    logic        req;
    logic        latch_en;
    logic        complete;
    logic        stall_raw;
    logic [31:0] cur_addr, cur_data;
    logic        cur_rd, cur_wr, cur_legal;
    logic        array_we;
    logic [31:0] array_rdata;

    assign req = mem_read_en | mem_write_en;

    // The access in flight is the live request in IDLE and the latched one in
    // WAIT, so completion logic below is shared by both LATENCY==0 and >0.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        latch_en  = 1'b0;
        complete  = 1'b0;
        stall_raw = 1'b0;
        cur_addr  = mem_addr;
        cur_data  = mem_data_out;
        cur_rd    = mem_read_en;
        cur_wr    = mem_write_en;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall_raw = 1'b1;
                        latch_en  = 1'b1;
                        cnt_d     = 3'(LATENCY - 1);
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                cur_addr = lat_addr;
                cur_data = lat_data;
                cur_rd   = lat_rd;
                cur_wr   = lat_wr;
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt != '0) begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt - 3'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
        cur_legal = is_legal(cur_addr, cur_rd, cur_wr, IDX_W);
    end

    assign array_we    = complete & cur_wr & cur_legal;
    assign mem_stall   = rst_n & stall_raw;
    assign mem_data_in = (rst_n && complete && cur_rd && cur_legal) ? array_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_rd   <= 1'b0;
            lat_wr   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (latch_en) begin
                lat_addr <= mem_addr;
                lat_data <= mem_data_out;
                lat_rd   <= mem_read_en;
                lat_wr   <= mem_write_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_fault  <= 1'b0;
            fault_addr <= '0;
        end else if (complete && !cur_legal) begin
            mem_fault <= 1'b1;
            if (!mem_fault) begin
                fault_addr <= cur_addr;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .we   (array_we),
        .waddr(cur_addr[IDX_W-1:0]),
        .wdata(cur_data),
        .raddr(cur_addr[IDX_W-1:0]),
        .rdata(array_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Five instances (LATENCY 0..4, DEPTH_WORDS 256) share clock, reset and
// request inputs; each scenario checks only the instance it targets.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;

    logic [31:0] data_v  [5];
    logic        stall_v [5];
    logic        fault_v [5];
    logic [31:0] faddr_v [5];

    int checks;
    int failures;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(data_v[0]),
        .mem_stall(stall_v[0]), .mem_fault(fault_v[0]), .fault_addr(faddr_v[0]));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(data_v[1]),
        .mem_stall(stall_v[1]), .mem_fault(fault_v[1]), .fault_addr(faddr_v[1]));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(data_v[2]),
        .mem_stall(stall_v[2]), .mem_fault(fault_v[2]), .fault_addr(faddr_v[2]));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(data_v[3]),
        .mem_stall(stall_v[3]), .mem_fault(fault_v[3]), .fault_addr(faddr_v[3]));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(data_v[4]),
        .mem_stall(stall_v[4]), .mem_fault(fault_v[4]), .fault_addr(faddr_v[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1);
    end

    // Called just after a rising edge; leaves just after a rising edge.
    task automatic do_reset();
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives one access on the shared request lines until instance sel shows a
    // non-stall cycle (bounded). nstall counts stall cycles seen (20 = no
    // completion), rdata is mem_data_in in the completion cycle, and dirty
    // flags any nonzero mem_data_in during a stall cycle.
    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int nstall, output logic [31:0] rdata,
                          output bit dirty);
        bit done;
        nstall = 0;
        rdata  = '0;
        dirty  = 1'b0;
        done   = 1'b0;
        mem_read_en  = rd;
        mem_write_en = wr;
        mem_addr     = a;
        mem_data_out = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (stall_v[sel]) begin
                nstall++;
                if (data_v[sel] !== '0) dirty = 1'b1;
            end else begin
                rdata = data_v[sel];
                done  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) nstall = 20;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        mem_read_en  = 1'b1;
        mem_write_en = 1'b0;
        mem_addr     = 32'd5;
        mem_data_out = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (stall_v[i] !== 1'b0 || data_v[i] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs[L%0d]: stall=%b data=%h, want stall=0 data=0",
                         i, stall_v[i], data_v[i]);
            end
            checks++;
            if (fault_v[i] !== 1'b0 || faddr_v[i] !== 32'h0) begin
                failures++;
                $display("FAIL reset_fault[L%0d]: fault=%b addr=%h, want fault=0 addr=0",
                         i, fault_v[i], faddr_v[i]);
            end
        end
        mem_read_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency1();
        int n; logic [31:0] r; bit dirty;
        do_reset();
        access(1, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, n, r, dirty);
        checks++;
        if (n !== 1 || r !== 32'h0) begin
            failures++;
            $display("FAIL l1_store: stalls=%0d data=%h, want stalls=1 data=0", n, r);
        end
        access(1, 1'b1, 1'b0, 32'd5, 32'h0, n, r, dirty);
        checks++;
        if (n !== 1 || r !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL l1_load: stalls=%0d data=%h, want stalls=1 data=deadbeef", n, r);
        end
        checks++;
        if (dirty !== 1'b0) begin
            failures++;
            $display("FAIL l1_stall_data: nonzero data during stall=%b, want 0", dirty);
        end
        checks++;
        if (fault_v[1] !== 1'b0) begin
            failures++;
            $display("FAIL l1_fault: fault=%b, want 0", fault_v[1]);
        end
    endtask

    task automatic test_latency0();
        int n; logic [31:0] r; bit dirty;
        do_reset();
        access(0, 1'b0, 1'b1, 32'd0, 32'h12345678, n, r, dirty);
        checks++;
        if (n !== 0 || r !== 32'h0) begin
            failures++;
            $display("FAIL l0_store: stalls=%0d data=%h, want stalls=0 data=0", n, r);
        end
        access(0, 1'b1, 1'b0, 32'd0, 32'h0, n, r, dirty);
        checks++;
        if (n !== 0 || r !== 32'h12345678) begin
            failures++;
            $display("FAIL l0_load: stalls=%0d data=%h, want stalls=0 data=12345678", n, r);
        end
    endtask

    task automatic test_addr_fault();
        int n; logic [31:0] r; bit dirty;
        do_reset();
        access(3, 1'b0, 1'b1, 32'd0, 32'hCAFE0000, n, r, dirty);
        checks++;
        if (n !== 3 || fault_v[3] !== 1'b0) begin
            failures++;
            $display("FAIL l3_legal_store: stalls=%0d fault=%b, want stalls=3 fault=0", n, fault_v[3]);
        end
        access(3, 1'b0, 1'b1, 32'h100, 32'h1, n, r, dirty);
        checks++;
        if (n !== 3 || fault_v[3] !== 1'b1 || faddr_v[3] !== 32'h100) begin
            failures++;
            $display("FAIL l3_oob_store: stalls=%0d fault=%b addr=%h, want stalls=3 fault=1 addr=100",
                     n, fault_v[3], faddr_v[3]);
        end
        access(3, 1'b0, 1'b1, 32'h200, 32'h2, n, r, dirty);
        checks++;
        if (fault_v[3] !== 1'b1 || faddr_v[3] !== 32'h100) begin
            failures++;
            $display("FAIL l3_second_fault: fault=%b addr=%h, want fault=1 addr=100",
                     fault_v[3], faddr_v[3]);
        end
        access(3, 1'b1, 1'b0, 32'h100, 32'h0, n, r, dirty);
        checks++;
        if (n !== 3 || r !== 32'h0) begin
            failures++;
            $display("FAIL l3_oob_load: stalls=%0d data=%h, want stalls=3 data=0", n, r);
        end
        access(3, 1'b1, 1'b0, 32'h0, 32'h0, n, r, dirty);
        checks++;
        if (r !== 32'hCAFE0000) begin
            failures++;
            $display("FAIL l3_no_alias: data=%h, want cafe0000", r);
        end
    endtask

    task automatic test_rw_fault();
        int n; logic [31:0] r; bit dirty;
        do_reset();
        access(2, 1'b0, 1'b1, 32'd7, 32'hAA, n, r, dirty);
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL l2_prefill: stalls=%0d, want 2", n);
        end
        access(2, 1'b1, 1'b1, 32'd7, 32'h55, n, r, dirty);
        checks++;
        if (n !== 2 || r !== 32'h0 || fault_v[2] !== 1'b1 || faddr_v[2] !== 32'd7) begin
            failures++;
            $display("FAIL l2_rw_fault: stalls=%0d data=%h fault=%b addr=%h, want 2 0 1 7",
                     n, r, fault_v[2], faddr_v[2]);
        end
        access(2, 1'b1, 1'b0, 32'd7, 32'h0, n, r, dirty);
        checks++;
        if (r !== 32'hAA) begin
            failures++;
            $display("FAIL l2_rw_nowrite: data=%h, want aa", r);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n; logic [31:0] r; bit dirty;
        do_reset();
        access(4, 1'b0, 1'b1, 32'd9, 32'h11, n, r, dirty);
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL l4_prefill: stalls=%0d, want 4", n);
        end
        mem_write_en = 1'b1;
        mem_addr     = 32'd9;
        mem_data_out = 32'h55;
        @(negedge clk);
        checks++;
        if (stall_v[4] !== 1'b1) begin
            failures++;
            $display("FAIL l4_first_stall: stall=%b, want 1", stall_v[4]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall_v[4] !== 1'b0 || data_v[4] !== 32'h0) begin
            failures++;
            $display("FAIL l4_async_reset: stall=%b data=%h, want stall=0 data=0",
                     stall_v[4], data_v[4]);
        end
        mem_write_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(4, 1'b1, 1'b0, 32'd9, 32'h0, n, r, dirty);
        checks++;
        if (n !== 4 || r !== 32'h11 || fault_v[4] !== 1'b0) begin
            failures++;
            $display("FAIL l4_after_reset: stalls=%0d data=%h fault=%b, want 4 11 0",
                     n, r, fault_v[4]);
        end
    endtask

    task automatic test_abort();
        int n; logic [31:0] r; bit dirty;
        do_reset();
        access(2, 1'b0, 1'b1, 32'd3, 32'h33, n, r, dirty);
        mem_write_en = 1'b1;
        mem_addr     = 32'd3;
        mem_data_out = 32'h99;
        @(negedge clk);
        checks++;
        if (stall_v[2] !== 1'b1) begin
            failures++;
            $display("FAIL l2_abort_stall: stall=%b, want 1", stall_v[2]);
        end
        @(posedge clk);
        #1;
        mem_write_en = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_v[2] !== 1'b0) begin
            failures++;
            $display("FAIL l2_abort_release: stall=%b, want 0", stall_v[2]);
        end
        @(posedge clk);
        #1;
        access(2, 1'b1, 1'b0, 32'd3, 32'h0, n, r, dirty);
        checks++;
        if (n !== 2 || r !== 32'h33 || fault_v[2] !== 1'b0) begin
            failures++;
            $display("FAIL l2_abort_load: stalls=%0d data=%h fault=%b, want 2 33 0",
                     n, r, fault_v[2]);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_data_out = '0;
        test_reset();
        test_latency1();
        test_latency0();
        test_addr_fault();
        test_rw_fault();
        test_reset_mid_wait();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder answering the execute stage's memory request interface.
  - Execute side drives: mem_read_en, mem_write_en, mem_addr, mem_data_out.
  - This block returns: mem_data_in.
- Word-addressed SRAM model with a parameterised wait-state count and a stall handshake that freezes the pipeline.
- Sits between the execute stage and the data address space.
- Reports illegal accesses through a sticky fault flag.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, ≥2.
- LATENCY, 1: wait-state cycles per access, 0..7.
- IDX_W, log2(DEPTH_WORDS): derived word-index width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read_en  in  1  load request from execute.
- mem_write_en  in  1  store request from execute.
- mem_addr  in  32  word address.
- mem_data_out  in  32  store data from execute.
- mem_data_in  out  32  load data to execute; valid only in the completion cycle.
- mem_stall  out  1  high = execute holds request and PC.
- mem_fault  out  1  sticky illegal-access flag.
- fault_addr  out  32  address of the first faulting access.

Behaviour:
- Reset (rst_n low, async):
  - FSM to IDLE, counter 0, mem_fault 0, fault_addr 0.
  - mem_stall and mem_data_in forced 0 while rst_n is low.
  - Array contents are not reset.
- req = mem_read_en | mem_write_en.
- Illegal access (fault) when either:
  - mem_addr[31:IDX_W] != 0, or
  - mem_read_en and mem_write_en are both high.
- FSM states: IDLE, WAIT.
  - IDLE, req, LATENCY>0:
    - mem_stall=1 combinationally.
    - Latch addr, write data and direction.
    - cnt<=LATENCY-1; go to WAIT.
  - IDLE, req, LATENCY==0: completion cycle immediately; stay in IDLE.
  - WAIT, cnt>0: mem_stall=1; cnt decrements.
  - WAIT, cnt==0: completion cycle; mem_stall=0; next state IDLE.
- Timing: a request first seen at cycle t has stall high for cycles t..t+LATENCY-1 and completes at t+LATENCY.
- Completion cycle:
  - Read: mem_data_in = array[latched idx] (array read is asynchronous).
  - Write: array[idx] <= data at the closing edge.
  - mem_data_in = 0 in every non-completion cycle and for writes.
- Back-to-back requests: the next request is accepted in the cycle after completion; there are no bubble-free consecutive accesses when LATENCY>0.
- Request stability: execute must hold addr, data and enables while stalled.
  - If req drops in WAIT: abort, return to IDLE, no write, no fault.
  - If addr or enables change in WAIT: the latched values win.
- Fault handling: a faulting access still takes the full latency.
  - Write is suppressed; a read returns 0.
  - mem_fault <= 1 at completion.
  - fault_addr is captured only if mem_fault was 0.
  - Both stay set until reset.
- Reset mid-WAIT: access dropped, no write; after rst_n rises the FSM sits in IDLE.
- Address wrap: none. Indices are direct and out-of-range is a fault, never aliased.

Decomposition:
- dmem_pkg holds:
  - state enum {IDLE, WAIT};
  - DEFAULT_DEPTH=256, DEFAULT_LATENCY=1;
  - helper function is_legal(addr, rd, wr, IDX_W).
- Sub-module dmem_array (DEPTH_WORDS x 32):
  - async read port, sync write port with write enable;
  - no reset.
- dmem_responder holds the FSM, the latch registers, the counter and fault logic.

Test Plan:
1. LATENCY=1: store mem_addr=5, data=0xDEADBEEF, then load addr 5 → stall high exactly 1 cycle per access; load completion cycle shows mem_data_in=0xDEADBEEF; mem_fault stays 0.
2. LATENCY=0: store addr 0 = 0x12345678, load addr 0 next cycle → mem_stall never asserts; mem_data_in=0x12345678 in the same cycle as the request.
3. LATENCY=3, DEPTH_WORDS=256: store addr 0x100 data 0x1 → stall 3 cycles, mem_fault=1, fault_addr=0x100; then store addr 0x200 → fault_addr still 0x100; load addr 0x100 → 0.
4. LATENCY=2: assert mem_read_en and mem_write_en together at addr 7 (prior contents 0xAA) → fault set, fault_addr=7, addr 7 still reads 0xAA afterwards.
5. LATENCY=4: store addr 9 = 0x55, pull rst_n low in the second stall cycle → mem_stall and mem_data_in drop to 0 immediately; after reset, load addr 9 returns the old value (not 0x55).
6. LATENCY=2: store addr 3, drop mem_write_en after 1 stall cycle → FSM returns to IDLE, addr 3 unchanged, no fault; a following load addr 3 completes normally after 2 stall cycles.
